// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM bank responder: command encoding and bank states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dram_pkg;

  // Command encoding on the cmd bus.
  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_ACT  = 2'b01;
  localparam logic [1:0] CMD_RDWR = 2'b10;
  localparam logic [1:0] CMD_PRE  = 2'b11;

  // Per-bank state machine states.
  typedef enum logic [1:0] {
    BANK_IDLE        = 2'd0,
    BANK_ACTIVATING  = 2'd1,
    BANK_ACTIVE      = 2'd2,
    BANK_PRECHARGING = 2'd3
  } bank_state_e;

endpackage

// File: rtl/dram_bank_fsm.sv
// Single-bank state machine: IDLE -> ACTIVATING -> ACTIVE -> PRECHARGING -> IDLE, with open-row latch.
// Latency: ACTIVE T_RCD edges after ACT accept, IDLE T_RP edges after PRE accept.
// Backpressure: none; commands illegal in the current state are refused through cmd_ok.
// Ports: cmd_vld marks a command addressed to this bank and not blocked by refresh; cmd_ok
// says whether cmd is legal right now; is_idle/bank_open report state; open_row is the latched row.
module dram_bank_fsm
  import dram_pkg::*;
#(
  parameter int ROW_W = 7,
  parameter int T_RCD = 2,
  parameter int T_RP  = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             cmd_vld,
  input  logic [1:0]       cmd,
  input  logic [ROW_W-1:0] row_addr,
  output logic             cmd_ok,
  output logic             is_idle,
  output logic             bank_open,
  output logic [ROW_W-1:0] open_row
);

  localparam int T_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  bank_state_e      state_q, state_d, eff_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= BANK_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    // A timed state whose counter has run out completes on this edge, so a
    // command sampled on the same edge already sees the destination state.
    // This is what lets ACT land exactly T_RP edges after PRE.
    eff_state = state_q;
    if (state_q == BANK_ACTIVATING && cnt_q == '0) begin
      eff_state = BANK_ACTIVE;
    end else if (state_q == BANK_PRECHARGING && cnt_q == '0) begin
      eff_state = BANK_IDLE;
    end

    case (cmd)
      CMD_NOP:  cmd_ok = 1'b1;
      CMD_ACT:  cmd_ok = (eff_state == BANK_IDLE);
      CMD_RDWR: cmd_ok = (eff_state == BANK_ACTIVE);
      default:  cmd_ok = (eff_state == BANK_IDLE) || (eff_state == BANK_ACTIVE);
    endcase

    state_d = eff_state;
    cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
    row_d   = row_q;
    if (cmd_vld && cmd_ok) begin
      if (cmd == CMD_ACT) begin
        state_d = BANK_ACTIVATING;
        cnt_d   = CNT_W'(T_RCD - 1);
        row_d   = row_addr;
      end else if (cmd == CMD_PRE && eff_state == BANK_ACTIVE) begin
        state_d = BANK_PRECHARGING;
        cnt_d   = CNT_W'(T_RP - 1);
      end
    end

    is_idle   = (eff_state == BANK_IDLE);
    bank_open = (state_q == BANK_ACTIVE);
    open_row  = row_q;
  end

endmodule

// File: rtl/dram_bank_responder.sv
// Multi-bank DRAM responder: per-bank FSMs, column memory, fixed-latency read pipe, refresh timer.
// Latency: read data T_CL edges after the RD accept edge; err one cycle after an illegal command.
// Backpressure: none; illegal or blocked commands are dropped and flagged on err.
// Ports: cmd/cs/row_addr/col_addr/we/wdata/refresh sampled every rising clk edge;
// rdata/rdata_valid read return; bank_open per-bank ACTIVE flags; ref_busy refresh window; err pulse.
module dram_bank_responder
  import dram_pkg::*;
#(
  parameter int DATA_WIDTH   = 1,
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int T_RCD        = 2,
  parameter int T_CL         = 2,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 4
) (
  input  logic                            clk,
  input  logic                            rst_b,
  input  logic [1:0]                      cmd,
  input  logic [$clog2(NUM_OF_BANKS)-1:0] cs,
  input  logic [$clog2(NUM_OF_ROWS)-1:0]  row_addr,
  input  logic [$clog2(NUM_OF_COLS)-1:0]  col_addr,
  input  logic                            we,
  input  logic [DATA_WIDTH-1:0]           wdata,
  input  logic                            refresh,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            rdata_valid,
  output logic [NUM_OF_BANKS-1:0]         bank_open,
  output logic                            ref_busy,
  output logic                            err
);

  localparam int BANK_W    = $clog2(NUM_OF_BANKS);
  localparam int ROW_W     = $clog2(NUM_OF_ROWS);
  localparam int COL_W     = $clog2(NUM_OF_COLS);
  localparam int MEM_AW    = BANK_W + ROW_W + COL_W;
  localparam int MEM_DEPTH = 1 << MEM_AW;
  localparam int RFC_W     = $clog2(T_RFC + 1);

  logic [NUM_OF_BANKS-1:0] bank_vld;
  logic [NUM_OF_BANKS-1:0] bank_cmd_ok;
  logic [NUM_OF_BANKS-1:0] bank_idle;
  logic [ROW_W-1:0]        bank_row [NUM_OF_BANKS];

  logic                    cmd_active, cmd_blocked, cmd_legal;
  logic                    ref_ok, err_d, wr_fire, rd_fire;
  logic [MEM_AW-1:0]       mem_addr;
  logic [RFC_W-1:0]        ref_cnt;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]   pipe_dat [T_CL];
  logic [T_CL-1:0]         pipe_vld;

  assign ref_busy = (ref_cnt != '0);

  always_comb begin
    cmd_active  = (cmd != CMD_NOP);
    // A refresh window, or a refresh request colliding with a command, blocks every bank.
    cmd_blocked = cmd_active && (ref_busy || refresh);
    cmd_legal   = cmd_active && !cmd_blocked && bank_cmd_ok[cs];
    ref_ok      = refresh && !cmd_active && !ref_busy && (&bank_idle);
    err_d       = (cmd_active && !cmd_legal) || (refresh && !ref_ok);
    wr_fire     = cmd_legal && (cmd == CMD_RDWR) && we;
    rd_fire     = cmd_legal && (cmd == CMD_RDWR) && !we;
    mem_addr    = {cs, bank_row[cs], col_addr};
  end

  for (genvar b = 0; b < NUM_OF_BANKS; b++) begin : g_bank
    assign bank_vld[b] = cmd_active && !cmd_blocked && (cs == BANK_W'(b));

    dram_bank_fsm #(
      .ROW_W (ROW_W),
      .T_RCD (T_RCD),
      .T_RP  (T_RP)
    ) u_bank (
      .clk       (clk),
      .rst_b     (rst_b),
      .cmd_vld   (bank_vld[b]),
      .cmd       (cmd),
      .row_addr  (row_addr),
      .cmd_ok    (bank_cmd_ok[b]),
      .is_idle   (bank_idle[b]),
      .bank_open (bank_open[b]),
      .open_row  (bank_row[b])
    );
  end

  // Storage contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[mem_addr] <= wdata;
    end
  end

  // Read pipe: stage 0 captures the array on the accept edge, the output
  // register takes the last stage, giving T_CL edges of latency and one
  // read per cycle. Reset drops anything still in flight.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pipe_vld    <= '0;
      for (int i = 0; i < T_CL; i++) begin
        pipe_dat[i] <= '0;
      end
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      pipe_vld[0] <= rd_fire;
      if (rd_fire) begin
        pipe_dat[0] <= mem[mem_addr];
      end
      for (int i = 1; i < T_CL; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
      rdata_valid <= pipe_vld[T_CL-1];
      if (pipe_vld[T_CL-1]) begin
        rdata <= pipe_dat[T_CL-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ref_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (ref_ok) begin
        ref_cnt <= RFC_W'(T_RFC);
      end else if (ref_busy) begin
        ref_cnt <= ref_cnt - RFC_W'(1);
      end
      err <= err_d;
    end
  end

endmodule

// File: tb/tb_dram_bank_responder.sv
module tb_dram_bank_responder;

  localparam int NB   = 8;
  localparam int NR   = 128;
  localparam int NC   = 8;
  localparam int TRCD = 2;
  localparam int TCL  = 2;
  localparam int TRP  = 2;
  localparam int TRFC = 4;

  localparam logic [1:0] N  = 2'b00;
  localparam logic [1:0] A  = 2'b01;
  localparam logic [1:0] RW = 2'b10;
  localparam logic [1:0] P  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_b;
  logic [1:0] cmd;
  logic [2:0] cs;
  logic [6:0] row_addr;
  logic [2:0] col_addr;
  logic       we;
  logic [0:0] wdata;
  logic       refresh;
  logic [0:0] rdata;
  logic       rdata_valid;
  logic [7:0] bank_open;
  logic       ref_busy;
  logic       err;

  always #5 clk = ~clk;

  dram_bank_responder #(
    .DATA_WIDTH(1), .NUM_OF_BANKS(NB), .NUM_OF_ROWS(NR), .NUM_OF_COLS(NC),
    .T_RCD(TRCD), .T_CL(TCL), .T_RP(TRP), .T_RFC(TRFC)
  ) dut (
    .clk(clk), .rst_b(rst_b), .cmd(cmd), .cs(cs), .row_addr(row_addr),
    .col_addr(col_addr), .we(we), .wdata(wdata), .refresh(refresh),
    .rdata(rdata), .rdata_valid(rdata_valid), .bank_open(bank_open),
    .ref_busy(ref_busy), .err(err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (timestamp based) ----------------
  int  n;                 // index of the current sampling edge since reset release
  bit  m_open [NB];       // last accepted bank command was ACT (1) or PRE (0)
  int  m_t    [NB];       // edge of that ACT/PRE
  int  m_row  [NB];
  int  ref_at;            // edge at which the last refresh was accepted
  bit  mem_m [NB][NR][NC];
  bit  mem_k [NB][NR][NC];
  typedef struct { int due; bit dat; bit known; } rd_t;
  rd_t rq[$];
  bit  e_err, e_vld, e_rd, e_rd_known, e_busy;
  logic [7:0] e_open;

  function automatic bit is_active(input int b);
    return m_open[b] && (n >= m_t[b] + TRCD);
  endfunction

  function automatic bit is_idle(input int b);
    return !m_open[b] && (n >= m_t[b] + TRP);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_open[b] = 1'b0;
      m_t[b]    = -1000;
      m_row[b]  = 0;
    end
    ref_at = -1000;
    rq.delete();
    n = 0;
    e_err = 0; e_vld = 0; e_rd = 0; e_rd_known = 1; e_busy = 0; e_open = '0;
  endtask

  task automatic model_edge();
    bit ill, busy, all_idle;
    int b;
    ill  = 1'b0;
    busy = (n > ref_at) && (n <= ref_at + TRFC);
    all_idle = 1'b1;
    for (int k = 0; k < NB; k++) if (!is_idle(k)) all_idle = 1'b0;
    b = int'(cs);
    if (refresh) begin
      if (cmd != N || busy || !all_idle) ill = 1'b1;
      else ref_at = n;
    end else if (cmd != N) begin
      if (busy) ill = 1'b1;
      else begin
        case (cmd)
          A: if (is_idle(b)) begin m_open[b] = 1'b1; m_t[b] = n; m_row[b] = int'(row_addr); end
             else ill = 1'b1;
          RW: if (is_active(b)) begin
                if (we) begin
                  mem_m[b][m_row[b]][col_addr] = wdata[0];
                  mem_k[b][m_row[b]][col_addr] = 1'b1;
                end else begin
                  rq.push_back('{n + TCL, mem_m[b][m_row[b]][col_addr], mem_k[b][m_row[b]][col_addr]});
                end
              end else ill = 1'b1;
          default: if (is_active(b)) begin m_open[b] = 1'b0; m_t[b] = n; end
                   else if (!is_idle(b)) ill = 1'b1;
        endcase
      end
    end
    e_err = ill;
    e_vld = 1'b0;
    if (rq.size() > 0 && rq[0].due == n) begin
      e_vld = 1'b1;
      e_rd_known = rq[0].known;
      if (rq[0].known) e_rd = rq[0].dat;
      void'(rq.pop_front());
    end
    e_busy = (n >= ref_at) && (n < ref_at + TRFC);
    for (int k = 0; k < NB; k++) e_open[k] = is_active(k);
    n++;
  endtask

  task automatic compare();
    check("rdata_valid", rdata_valid, e_vld);
    if (e_rd_known) check("rdata", rdata, e_rd);
    check("err", err, e_err);
    check("ref_busy", ref_busy, e_busy);
    check("bank_open", bank_open, e_open);
  endtask

  task automatic drive(input logic [1:0] c, input int b, input int r, input int cl,
                       input bit w, input bit d, input bit rf);
    cmd = c; cs = 3'(b); row_addr = 7'(r); col_addr = 3'(cl);
    we = w; wdata = d; refresh = rf;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0] c; int bk; int row; int col; bit w; bit d; bit rf;
    bit x_err; logic [7:0] x_open; bit x_vld; bit x_rd; bit x_busy;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [1:0] c, input int bk, input int row, input int col,
                     input bit w, input bit d, input bit rf, input bit x_err,
                     input logic [7:0] x_open, input bit x_vld, input bit x_rd, input bit x_busy);
    tbl.push_back('{c, bk, row, col, w, d, rf, x_err, x_open, x_vld, x_rd, x_busy});
  endtask

  task automatic refresh_burst();
    drive(N, 0, 0, 0, 0, 0, 0);
    repeat (3) step();
    for (int b = 0; b < NB; b++) begin drive(P, b, 0, 0, 0, 0, 0); step(); end
    drive(N, 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    drive(N, 0, 0, 0, 0, 0, 1);
    step();
    check("burst_ref_busy", ref_busy, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    //  cmd bk row col we wd rf | err open  vld rd busy
    add(A,  3, 5, 0, 0, 0, 0,  0, 8'h00, 0, 0, 0);   // 0  ACT b3 r5
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h00, 0, 0, 0);   // 1
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h08, 0, 0, 0);   // 2  open two edges later
    add(RW, 3, 0, 2, 1, 1, 0,  0, 8'h08, 0, 0, 0);   // 3  WR c2=1
    add(RW, 3, 0, 2, 0, 0, 0,  0, 8'h08, 0, 0, 0);   // 4  RD c2
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h08, 0, 0, 0);   // 5
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h08, 1, 1, 0);   // 6  data two edges after RD
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h08, 0, 1, 0);   // 7  rdata holds
    add(RW, 3, 0, 0, 1, 1, 0,  0, 8'h08, 0, 1, 0);   // 8  preload 1,0,1,1
    add(RW, 3, 0, 1, 1, 0, 0,  0, 8'h08, 0, 1, 0);   // 9
    add(RW, 3, 0, 2, 1, 1, 0,  0, 8'h08, 0, 1, 0);   // 10
    add(RW, 3, 0, 3, 1, 1, 0,  0, 8'h08, 0, 1, 0);   // 11
    add(RW, 3, 0, 0, 0, 0, 0,  0, 8'h08, 0, 1, 0);   // 12 four back-to-back reads
    add(RW, 3, 0, 1, 0, 0, 0,  0, 8'h08, 0, 1, 0);   // 13
    add(RW, 3, 0, 2, 0, 0, 0,  0, 8'h08, 1, 1, 0);   // 14
    add(RW, 3, 0, 3, 0, 0, 0,  0, 8'h08, 1, 0, 0);   // 15
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h08, 1, 1, 0);   // 16
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h08, 1, 1, 0);   // 17
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h08, 0, 1, 0);   // 18
    add(RW, 3, 0, 4, 1, 0, 0,  0, 8'h08, 0, 1, 0);   // 19 WR c4=0
    add(RW, 3, 0, 4, 0, 0, 0,  0, 8'h08, 0, 1, 0);   // 20 RD c4 right after write
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h08, 0, 1, 0);   // 21
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h08, 1, 0, 0);   // 22
    add(RW, 0, 0, 0, 0, 0, 0,  1, 8'h08, 0, 0, 0);   // 23 RD to idle bank 0
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h08, 0, 0, 0);   // 24
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h08, 0, 0, 0);   // 25 no data for refused read
    add(A,  0, 1, 0, 0, 0, 0,  0, 8'h08, 0, 0, 0);   // 26 ACT b0
    add(A,  0, 1, 0, 0, 0, 0,  1, 8'h08, 0, 0, 0);   // 27 second ACT illegal
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h09, 0, 0, 0);   // 28
    add(P,  3, 0, 0, 0, 0, 0,  0, 8'h01, 0, 0, 0);   // 29 PRE b3
    add(A,  3, 7, 0, 0, 0, 0,  1, 8'h01, 0, 0, 0);   // 30 ACT at PRE+1 illegal
    add(A,  3, 7, 0, 0, 0, 0,  0, 8'h01, 0, 0, 0);   // 31 ACT at PRE+2 accepted
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h01, 0, 0, 0);   // 32
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h09, 0, 0, 0);   // 33
    add(N,  0, 0, 0, 0, 0, 1,  1, 8'h09, 0, 0, 0);   // 34 refresh with banks open
    add(P,  0, 0, 0, 0, 0, 0,  0, 8'h08, 0, 0, 0);   // 35
    add(P,  3, 0, 0, 0, 0, 0,  0, 8'h00, 0, 0, 0);   // 36
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h00, 0, 0, 0);   // 37
    add(N,  0, 0, 0, 0, 0, 1,  0, 8'h00, 0, 0, 1);   // 38 refresh accepted
    add(A,  2, 0, 0, 0, 0, 0,  1, 8'h00, 0, 0, 1);   // 39 ACT during refresh
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h00, 0, 0, 1);   // 40
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h00, 0, 0, 1);   // 41
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h00, 0, 0, 0);   // 42 busy exactly 4 cycles
    add(P,  2, 0, 0, 0, 0, 0,  0, 8'h00, 0, 0, 0);   // 43 PRE to idle: no-op
    add(A,  1, 2, 0, 0, 0, 1,  1, 8'h00, 0, 0, 0);   // 44 refresh + ACT together
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h00, 0, 0, 0);   // 45
    add(A,  1, 2, 0, 0, 0, 0,  0, 8'h00, 0, 0, 0);   // 46
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h00, 0, 0, 0);   // 47
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h02, 0, 0, 0);   // 48
    add(N,  0, 0, 0, 0, 0, 1,  1, 8'h02, 0, 0, 0);   // 49 refresh with bank 1 open
    add(N,  0, 0, 0, 0, 0, 0,  0, 8'h02, 0, 0, 0);   // 50

    // Reset state.
    rst_b = 1'b0;
    drive(N, 0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    compare();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].c, tbl[i].bk, tbl[i].row, tbl[i].col, tbl[i].w, tbl[i].d, tbl[i].rf);
      step();
      check($sformatf("vec%0d_err", i), err, tbl[i].x_err);
      check($sformatf("vec%0d_open", i), bank_open, tbl[i].x_open);
      check($sformatf("vec%0d_vld", i), rdata_valid, tbl[i].x_vld);
      check($sformatf("vec%0d_rdata", i), rdata, tbl[i].x_rd);
      check($sformatf("vec%0d_busy", i), ref_busy, tbl[i].x_busy);
    end

    // Read in flight when reset hits: dropped, outputs cleared.
    drive(RW, 1, 0, 0, 1, 1, 0); step();
    drive(RW, 1, 0, 0, 0, 0, 0); step();
    drive(N, 0, 0, 0, 0, 0, 0);  step(); step();
    check("pre_reset_rdata", rdata, 1);
    drive(RW, 1, 0, 0, 0, 0, 0); step();
    drive(A, 1, 3, 0, 0, 0, 0);  step();
    check("pre_reset_err", err, 1);
    rst_b = 1'b0;
    model_reset();
    #1;
    check("rst_rdata", rdata, 0);
    check("rst_rdata_valid", rdata_valid, 0);
    check("rst_bank_open", bank_open, 0);
    check("rst_ref_busy", ref_busy, 0);
    check("rst_err", err, 0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    drive(N, 0, 0, 0, 0, 0, 0);
    repeat (4) begin
      step();
      check("post_rst_no_valid", rdata_valid, 0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [1:0] c;
      bit rf;
      if (i % 250 == 249) begin
        refresh_burst();
        continue;
      end
      r  = $urandom_range(0, 99);
      rf = (r < 4);
      if (rf) c = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : N;
      else if (r < 30) c = N;
      else if (r < 55) c = A;
      else if (r < 85) c = RW;
      else c = P;
      drive(c, $urandom_range(0, NB - 1), $urandom_range(0, 3), $urandom_range(0, NC - 1),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rf);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dram_bank_responder.md
DRAM_BANK_RESPONDER -- requirements
Module: dram_bank_responder

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 1, data bits per column.
- NUM_OF_BANKS, 8, number of banks.
- NUM_OF_ROWS, 128, rows per bank.
- NUM_OF_COLS, 8, columns per row.
- T_RCD, 2, cycles from ACT to bank ACTIVE.
- T_CL, 2, read latency in cycles.
- T_RP, 2, cycles from PRE to bank IDLE.
- T_RFC, 4, refresh busy cycles.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  the single clock, rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- cmd  in  2  command: 00 NOP, 01 ACT, 10 RDWR, 11 PRE.
- cs  in  clog2(NUM_OF_BANKS)  target bank.
- row_addr  in  clog2(NUM_OF_ROWS)  row for ACT.
- col_addr  in  clog2(NUM_OF_COLS)  column for RDWR.
- we  in  1  RDWR qualifier: 1 write, 0 read.
- wdata  in  DATA_WIDTH  write data.
- refresh  in  1  refresh request pulse.
- rdata  out  DATA_WIDTH  read data.
- rdata_valid  out  1  rdata qualifier.
- bank_open  out  NUM_OF_BANKS  per-bank ACTIVE flag.
- ref_busy  out  1  refresh in progress.
- err  out  1  one-cycle illegal-command pulse.

Function
REQ-003 The block SHALL sample cmd, cs, addresses, we, wdata and refresh on every rising clk edge.
REQ-004 Each bank SHALL run an FSM with states IDLE, ACTIVATING, ACTIVE, PRECHARGING.
REQ-005 ACT to an IDLE bank SHALL latch row_addr as the bank's open row and enter ACTIVATING; the bank SHALL enter ACTIVE exactly T_RCD cycles after the accept edge.
REQ-006 PRE to an ACTIVE bank SHALL enter PRECHARGING; the bank SHALL return to IDLE T_RP cycles later. PRE to an IDLE bank SHALL be a legal no-op.
REQ-007 RDWR with we=1 to an ACTIVE bank SHALL write wdata to mem[cs][open_row][col_addr] at the accept edge.
REQ-008 RDWR with we=0 to an ACTIVE bank SHALL read mem[cs][open_row][col_addr] at the accept edge. rdata SHALL be presented with rdata_valid=1 for one cycle, exactly T_CL cycles after the accept edge.
REQ-009 The read path SHALL be a T_CL-deep pipeline that accepts one read per cycle with no bubbles.
REQ-010 A read accepted one cycle after a write to the same location SHALL return the written data.
REQ-011 rdata SHALL hold its last value while rdata_valid=0.
REQ-012 The following SHALL be illegal: ACT to a non-IDLE bank; RDWR to a non-ACTIVE bank; PRE to an ACTIVATING or PRECHARGING bank. An illegal command SHALL be ignored, with err=1 in the following cycle.
REQ-013 refresh with all banks IDLE and ref_busy=0 SHALL set ref_busy for exactly T_RFC cycles. Any other refresh SHALL be ignored with err=1.
REQ-014 While ref_busy=1, any cmd other than NOP SHALL be ignored with err=1.
REQ-015 If refresh=1 and cmd is not NOP in the same cycle, both SHALL be ignored, with err=1.
REQ-016 Commands to different banks on consecutive cycles SHALL proceed independently. Already-issued reads SHALL complete regardless of later PRE.
REQ-017 bank_open[b] SHALL be 1 only in the ACTIVE state.

Reset
REQ-018 On rst_b=0 the block SHALL asynchronously set:
- all banks IDLE; all counters 0.
- read pipeline flushed.
- rdata=0, rdata_valid=0, bank_open=0, ref_busy=0, err=0.
REQ-019 Reset SHALL NOT initialise the memory array. Reads in flight during reset SHALL be dropped, with no rdata_valid after release.
REQ-020 The first commands SHALL be accepted on the first rising edge with rst_b=1.

Structure
REQ-021 A shared package dram_pkg SHALL hold the cmd encoding constants and the bank-state enumeration.
REQ-022 The per-bank FSM and timing counter SHALL be a sub-module dram_bank_fsm, instantiated NUM_OF_BANKS times.
REQ-023 The memory array, read pipeline and refresh logic SHALL reside in the top module.

Verification
REQ-024 ACT bank 3 row 5 -> bank_open[3]=1 two cycles later; WR col 2 data 1; RD col 2 -> rdata=1, rdata_valid=1 exactly 2 cycles after the RD edge.
REQ-025 RD to bank 0 while IDLE -> err=1 next cycle, no rdata_valid. ACT bank 0 twice back to back -> second yields err=1.
REQ-026 Four back-to-back reads, cols 0..3 preloaded 1,0,1,1 -> rdata_valid high 4 consecutive cycles, data 1,0,1,1.
REQ-027 refresh with all banks IDLE -> ref_busy=1 for 4 cycles; ACT during ref_busy -> err=1, bank stays IDLE. refresh with bank 1 ACTIVE -> err=1, ref_busy=0.
REQ-028 Issue RD, then assert rst_b=0 one cycle later -> no rdata_valid after release; all outputs 0.
REQ-029 PRE bank 3 -> bank_open[3]=0 next cycle; ACT bank 3 one cycle after PRE -> err=1; ACT at PRE+2 -> accepted.
